// File: rtl/uart_rx_fifo.sv
// UART receiver: synchronizes and deframes Rx, checks parity/stop/break and
// queues {errors, data} words in a FIFO drained by Read_Done rising edges.
module uart_rx_fifo #(
    parameter int SYSCLK_RATE = 100000000,
    parameter int BAUD_RATE   = 9600,
    parameter int DATA_BITS   = 8,
    parameter int PARITY_BIT  = 1,
    parameter int STOP_BITS   = 2,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic                 SysClk,
    input  logic                 Rst,
    input  logic                 Rx,
    input  logic                 Read_Done,
    output logic [DATA_BITS-1:0] Data_Out,
    output logic                 Data_Rdy,
    output logic [2:0]           Rx_Error,
    output logic                 FIFO_Empty,
    output logic                 FIFO_Full,
    output logic                 FIFO_Overflow,
    output logic                 RTS
);
    localparam int CLKS_PER_BIT = SYSCLK_RATE / BAUD_RATE;
    localparam int CNT_W  = $clog2(CLKS_PER_BIT + 1);
    localparam int BIT_W  = $clog2(DATA_BITS + 1);
    localparam int AW     = $clog2(FIFO_DEPTH);
    localparam int CW     = $clog2(FIFO_DEPTH + 1);
    localparam int WORD_W = DATA_BITS + 3;
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_HALF  = CNT_W'(CLKS_PER_BIT / 2);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [BIT_W-1:0] LAST_DATA = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0] LAST_STOP = BIT_W'(STOP_BITS - 1);
    localparam logic [CW-1:0]    LVL_FULL  = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0]    LVL_RTS   = CW'(FIFO_DEPTH - 1);

    function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
        return ^d;
    endfunction

    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_t;

    state_t                state_r, state_s;
    logic                  rx_meta_r, rx_sync_r;
    logic [CNT_W-1:0]      cnt_r, cnt_s;
    logic [BIT_W-1:0]      bit_idx_r, bit_idx_s;
    logic [DATA_BITS-1:0]  shift_r, shift_s;
    logic                  par_err_r, par_err_s, par_zero_r, par_zero_s;
    logic                  frm_err_r, frm_err_s, brk_r, brk_s;
    logic                  brk_now_s, frm_now_s, tick_s;
    logic                  push_r, push_s;
    logic [WORD_W-1:0]     push_word_r, push_word_s;

    logic [WORD_W-1:0]     mem_r [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr_r, rd_ptr_r;
    logic [CW-1:0]         count_r, count_s;
    logic                  rd_d_r, pop_s, push_ok_s, ovf_s;
    logic [DATA_BITS-1:0]  data_out_r;
    logic [2:0]            rx_err_r;
    logic                  empty_r, full_r, rdy_r, rts_r, ovf_r;

    // Two-flop synchronizer for the asynchronous Rx line (idles high)
    always_ff @(posedge SysClk) begin
        if (!Rst) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
        end else begin
            rx_meta_r <= Rx;
            rx_sync_r <= rx_meta_r;
        end
    end

    // Deframing FSM: next state, bit timing and error accumulation
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        bit_idx_s   = bit_idx_r;
        shift_s     = shift_r;
        par_err_s   = par_err_r;
        par_zero_s  = par_zero_r;
        frm_err_s   = frm_err_r;
        brk_s       = brk_r;
        push_s      = 1'b0;
        push_word_s = push_word_r;
        brk_now_s   = brk_r;
        frm_now_s   = frm_err_r;
        tick_s      = (cnt_r == CNT_ONE);
        case (state_r)
            ST_IDLE: begin
                if (!rx_sync_r) begin
                    state_s    = ST_START;
                    cnt_s      = CNT_HALF;
                    bit_idx_s  = '0;
                    par_err_s  = 1'b0;
                    par_zero_s = 1'b1;
                    frm_err_s  = 1'b0;
                    brk_s      = 1'b0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (tick_s) begin
                    cnt_s   = CNT_FULL;
                    state_s = rx_sync_r ? ST_IDLE : ST_DATA;
                end else begin
                    cnt_s = cnt_r - CNT_ONE;
                end
            end
            ST_DATA: begin
                if (tick_s) begin
                    cnt_s   = CNT_FULL;
                    shift_s = {rx_sync_r, shift_r[DATA_BITS-1:1]};
                    if (bit_idx_r == LAST_DATA) begin
                        bit_idx_s = '0;
                        state_s   = (PARITY_BIT != 0) ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_idx_s = bit_idx_r + BIT_W'(1);
                    end
                end else begin
                    cnt_s = cnt_r - CNT_ONE;
                end
            end
            ST_PARITY: begin
                if (tick_s) begin
                    cnt_s      = CNT_FULL;
                    par_err_s  = (even_parity(shift_r) != rx_sync_r);
                    par_zero_s = ~rx_sync_r;
                    state_s    = ST_STOP;
                end else begin
                    cnt_s = cnt_r - CNT_ONE;
                end
            end
            ST_STOP: begin
                if (tick_s) begin
                    cnt_s     = CNT_FULL;
                    bit_idx_s = bit_idx_r + BIT_W'(1);
                    // Break is judged on the first stop sample only
                    brk_now_s = (bit_idx_r == '0) ? ((shift_r == '0) && par_zero_r && !rx_sync_r) : brk_r;
                    frm_now_s = frm_err_r | ~rx_sync_r;
                    brk_s     = brk_now_s;
                    frm_err_s = frm_now_s;
                    if (bit_idx_r == LAST_STOP) begin
                        push_s      = 1'b1;
                        push_word_s = {brk_now_s, frm_now_s | brk_now_s, par_err_r, shift_r};
                        state_s     = ST_IDLE;
                    end else begin
                        state_s = ST_STOP;
                    end
                end else begin
                    cnt_s = cnt_r - CNT_ONE;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Deframing FSM registers
    always_ff @(posedge SysClk) begin
        if (!Rst) begin
            state_r     <= ST_IDLE;
            cnt_r       <= '0;
            bit_idx_r   <= '0;
            shift_r     <= '0;
            par_err_r   <= 1'b0;
            par_zero_r  <= 1'b1;
            frm_err_r   <= 1'b0;
            brk_r       <= 1'b0;
            push_r      <= 1'b0;
            push_word_r <= '0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            bit_idx_r   <= bit_idx_s;
            shift_r     <= shift_s;
            par_err_r   <= par_err_s;
            par_zero_r  <= par_zero_s;
            frm_err_r   <= frm_err_s;
            brk_r       <= brk_s;
            push_r      <= push_s;
            push_word_r <= push_word_s;
        end
    end

    // FIFO push/pop arbitration; a full FIFO still accepts a push alongside a pop
    always_comb begin
        pop_s     = Read_Done && !rd_d_r && (count_r != '0);
        push_ok_s = push_r && ((count_r != LVL_FULL) || pop_s);
        ovf_s     = push_r && !push_ok_s;
        case ({push_ok_s, pop_s})
            2'b10:   count_s = count_r + CW'(1);
            2'b01:   count_s = count_r - CW'(1);
            default: count_s = count_r;
        endcase
    end

    // FIFO storage
    always_ff @(posedge SysClk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= push_word_r;
        end
    end

    // FIFO pointers, output word and status flags
    always_ff @(posedge SysClk) begin
        if (!Rst) begin
            rd_d_r     <= 1'b0;
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            count_r    <= '0;
            data_out_r <= '0;
            rx_err_r   <= 3'b000;
            empty_r    <= 1'b1;
            full_r     <= 1'b0;
            rdy_r      <= 1'b0;
            rts_r      <= 1'b1;
            ovf_r      <= 1'b0;
        end else begin
            rd_d_r  <= Read_Done;
            count_r <= count_s;
            empty_r <= (count_s == '0);
            full_r  <= (count_s == LVL_FULL);
            rdy_r   <= (count_s != '0);
            rts_r   <= (count_s < LVL_RTS);
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r               <= rd_ptr_r + AW'(1);
                {rx_err_r, data_out_r} <= mem_r[rd_ptr_r];
                ovf_r                  <= 1'b0;
            end else if (ovf_s) begin
                ovf_r <= 1'b1;
            end
        end
    end

    assign Data_Out      = data_out_r;
    assign Rx_Error      = rx_err_r;
    assign Data_Rdy      = rdy_r;
    assign FIFO_Empty    = empty_r;
    assign FIFO_Full     = full_r;
    assign FIFO_Overflow = ovf_r;
    assign RTS           = rts_r;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed frames plus random traffic
// compared against a queue-based model of received words and FIFO state.
module tb_uart_rx_fifo;
    logic       SysClk = 1'b0;
    logic       Rst, Rx, Read_Done;
    logic [7:0] Data_Out;
    logic       Data_Rdy, FIFO_Empty, FIFO_Full, FIFO_Overflow, RTS;
    logic [2:0] Rx_Error;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [10:0] exp_q[$];
    logic [7:0] exp_data = 8'h00;
    logic [2:0] exp_err  = 3'b000;
    logic       exp_ovf  = 1'b0;

    uart_rx_fifo #(
        .SYSCLK_RATE(1600), .BAUD_RATE(100), .DATA_BITS(8),
        .PARITY_BIT(1), .STOP_BITS(2), .FIFO_DEPTH(8)
    ) dut (
        .SysClk(SysClk), .Rst(Rst), .Rx(Rx), .Read_Done(Read_Done),
        .Data_Out(Data_Out), .Data_Rdy(Data_Rdy), .Rx_Error(Rx_Error),
        .FIFO_Empty(FIFO_Empty), .FIFO_Full(FIFO_Full),
        .FIFO_Overflow(FIFO_Overflow), .RTS(RTS)
    );

    always #5 SysClk = ~SysClk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, expv);
        end
    endtask

    task automatic check_status(input string tag);
        check({tag, "/empty"}, FIFO_Empty, exp_q.size() == 0);
        check({tag, "/rdy"},   Data_Rdy,   exp_q.size() != 0);
        check({tag, "/full"},  FIFO_Full,  exp_q.size() == 8);
        check({tag, "/rts"},   RTS,        exp_q.size() < 7);
        check({tag, "/ovf"},   FIFO_Overflow, exp_ovf);
        check({tag, "/data"},  Data_Out, exp_data);
        check({tag, "/err"},   Rx_Error, exp_err);
    endtask

    function automatic void model_pop();
        logic [10:0] w;
        if (exp_q.size() > 0) begin
            w        = exp_q.pop_front();
            exp_data = w[7:0];
            exp_err  = w[10:8];
            exp_ovf  = 1'b0;
        end
    endfunction

    // One 12-bit frame (start, 8 data LSB first, parity, 2 stops) then one idle bit.
    // pop_at >= 0 raises Read_Done at that clock offset within the frame.
    task automatic send_frame(input logic [7:0] d, input logic p, input logic s1,
                              input logic s2, input int pop_at);
        logic [11:0] bits;
        logic        par, brk, frm;
        bits = {s2, s1, p, d, 1'b0};
        for (int i = 0; i < 192; i++) begin
            Rx = bits[i / 16];
            if (i == pop_at) Read_Done = 1'b1;
            if (i == pop_at + 2) Read_Done = 1'b0;
            @(negedge SysClk);
        end
        Rx = 1'b1;
        repeat (16) @(negedge SysClk);
        par = ((^d) != p);
        brk = (d == 8'h00) && !p && !s1;
        frm = !s1 || !s2 || brk;
        if (pop_at >= 0) model_pop();
        if (exp_q.size() < 8) exp_q.push_back({brk, frm, par, d});
        else exp_ovf = 1'b1;
    endtask

    task automatic good_frame(input logic [7:0] d);
        send_frame(d, ^d, 1'b1, 1'b1, -1);
    endtask

    task automatic read_word(input string tag);
        Read_Done = 1'b1;
        @(negedge SysClk);
        Read_Done = 1'b0;
        @(negedge SysClk);
        model_pop();
        check_status(tag);
    endtask

    initial begin
        logic [8:0] pb;
        logic [7:0] d;
        Rst = 1'b0; Rx = 1'b1; Read_Done = 1'b0;
        repeat (3) @(negedge SysClk);
        check_status("reset");
        Rst = 1'b1;
        @(negedge SysClk);

        send_frame(8'hA5, 1'b0, 1'b1, 1'b1, -1);
        check_status("good_push");
        read_word("good_read");

        send_frame(8'h01, 1'b0, 1'b1, 1'b1, -1);
        read_word("bad_parity");
        send_frame(8'h3C, 1'b0, 1'b0, 1'b1, -1);
        read_word("bad_stop");

        send_frame(8'h00, 1'b0, 1'b0, 1'b0, -1);
        check_status("break_push");
        read_word("break_read");
        Rx = 1'b0;
        repeat (4) @(negedge SysClk);
        Rx = 1'b1;
        repeat (40) @(negedge SysClk);
        check_status("glitch");

        for (int k = 0; k < 9; k++) begin
            good_frame(8'(k));
            check_status($sformatf("fill%0d", k));
        end
        for (int k = 0; k < 8; k++) read_word($sformatf("drain%0d", k));
        read_word("drain_empty");

        for (int k = 0; k < 8; k++) good_frame(8'($urandom));
        check_status("refill");
        send_frame(8'hEE, 1'b0, 1'b1, 1'b1, 187);
        check_status("push_pop_full");
        for (int k = 0; k < 8; k++) read_word($sformatf("pp_drain%0d", k));

        good_frame(8'h34);
        read_word("pre_reset_read");
        good_frame(8'h12);
        pb = {8'h55, 1'b0};
        for (int i = 0; i < 64; i++) begin
            Rx = pb[i / 16];
            @(negedge SysClk);
        end
        Rx = 1'b1; Rst = 1'b0;
        @(negedge SysClk);
        Rst = 1'b1;
        exp_q.delete();
        exp_data = 8'h00; exp_err = 3'b000; exp_ovf = 1'b0;
        check_status("midframe_reset");
        repeat (200) @(negedge SysClk);
        check_status("post_reset_idle");
        send_frame(8'h81, 1'b0, 1'b1, 1'b1, -1);
        read_word("post_reset_frame");

        for (int n = 0; n < 30; n++) begin
            d = 8'($urandom);
            send_frame(d, (^d) ^ ($urandom_range(0, 3) == 0),
                       $urandom_range(0, 5) != 0, $urandom_range(0, 5) != 0,
                       ($urandom_range(0, 3) == 0) ? 187 : -1);
            check_status($sformatf("rnd_frame%0d", n));
            repeat ($urandom_range(0, 2)) read_word($sformatf("rnd_read%0d", n));
        end
        while (exp_q.size() > 0) read_word("final_drain");
        read_word("final_empty");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
